// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (ROL/SLL/ROR/SRA): one log-step per stage, valid/ready with full stall.
// Optional out_zero flag when SHIFTER_FLAGS_EN is defined.
module pipelined_shifter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef SHIFTER_FLAGS_EN
  ,
  output logic             out_zero
`endif
);

  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_SLL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRA = 2'b11
  } op_t;

  logic [WIDTH-1:0] data_q [CNT_W];
  logic [CNT_W-1:0] rem_q  [CNT_W];
  op_t              op_q   [CNT_W];
  logic [TAG_W-1:0] tag_q  [CNT_W];
  logic [CNT_W-1:0] valid_q;

  logic [WIDTH-1:0] nxt_data [CNT_W];
  logic [CNT_W-1:0] nxt_rem  [CNT_W];
  op_t              nxt_op   [CNT_W];
  logic [TAG_W-1:0] nxt_tag  [CNT_W];
  logic [CNT_W-1:0] nxt_valid;

  logic advance;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d, input op_t op,
                                            input int unsigned s);
    case (op)
      OP_ROL:  return (d << s) | (d >> (WIDTH - s));
      OP_SLL:  return d << s;
      OP_ROR:  return (d >> s) | (d << (WIDTH - s));
      default: return $signed(d) >>> s;
    endcase
  endfunction

  assign advance   = !valid_q[CNT_W-1] || out_ready;
  assign in_ready  = advance;
  assign out_valid = valid_q[CNT_W-1];
  assign out_data  = data_q[CNT_W-1];
  assign out_tag   = tag_q[CNT_W-1];

  // Count is consumed LSB-first: each stage tests bit 0 and hands the rest on shifted down.
  always_comb begin
    nxt_data[0]  = in_cnt[0] ? step(in_data, op_t'(in_op), 1) : in_data;
    nxt_rem[0]   = in_cnt >> 1;
    nxt_op[0]    = op_t'(in_op);
    nxt_tag[0]   = in_tag;
    nxt_valid[0] = in_valid;
    for (int unsigned k = 1; k < CNT_W; k++) begin
      nxt_data[k]  = rem_q[k-1][0] ? step(data_q[k-1], op_q[k-1], 2**k) : data_q[k-1];
      nxt_rem[k]   = rem_q[k-1] >> 1;
      nxt_op[k]    = op_q[k-1];
      nxt_tag[k]   = tag_q[k-1];
      nxt_valid[k] = valid_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned k = 0; k < CNT_W; k++) begin
        data_q[k] <= '0;
        rem_q[k]  <= '0;
        op_q[k]   <= OP_ROL;
        tag_q[k]  <= '0;
      end
    end else if (advance) begin
      valid_q <= nxt_valid;
      for (int unsigned k = 0; k < CNT_W; k++) begin
        data_q[k] <= nxt_data[k];
        rem_q[k]  <= nxt_rem[k];
        op_q[k]   <= nxt_op[k];
        tag_q[k]  <= nxt_tag[k];
      end
    end
  end

`ifdef SHIFTER_FLAGS_EN
  assign out_zero = (out_data == '0);
`endif

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed self-checking bench for pipelined_shifter at WIDTH=16 (out_zero checks with SHIFTER_FLAGS_EN).
module tb_pipelined_shifter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [3:0]  in_cnt = '0;
  logic [1:0]  in_op = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [3:0]  out_tag;
`ifdef SHIFTER_FLAGS_EN
  logic        out_zero;
`endif

  int total = 0;
  int bad = 0;

  // Stream table: op, data, cnt and the hand-computed result.
  logic [1:0]  v_op   [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
  logic [15:0] v_data [8] = '{16'h1234, 16'h1234, 16'h1234, 16'h8234,
                              16'hF000, 16'hFFFF, 16'h00F0, 16'h4000};
  logic [3:0]  v_cnt  [8] = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd2, 4'd15, 4'd8, 4'd14};
  logic [15:0] v_exp  [8] = '{16'h2341, 16'h2340, 16'h4123, 16'hF823,
                              16'hC003, 16'h8000, 16'hF000, 16'h0001};

  pipelined_shifter #(.WIDTH(16), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_cnt(in_cnt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
`ifdef SHIFTER_FLAGS_EN
    , .out_zero(out_zero)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one op into an empty pipeline and wait (bounded) for its result.
  task automatic do_op(input logic [15:0] d, input logic [3:0] c, input logic [1:0] o,
                       input logic [3:0] t, output logic [15:0] rd, output logic [3:0] rt,
                       output int lat);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = d; in_cnt = c; in_op = o; in_tag = t;
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 20);
    rd = out_data;
    rt = out_tag;
  endtask

  task automatic test_reset();
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 16'h0) begin bad++; $display("FAIL rst_data: got %h want 0000", out_data); end
    total++; if (out_tag !== 4'h0) begin bad++; $display("FAIL rst_tag: got %h want 0", out_tag); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", in_ready); end
`ifdef SHIFTER_FLAGS_EN
    total++; if (out_zero !== 1'b1) begin bad++; $display("FAIL rst_zero: got %b want 1", out_zero); end
`endif
    #21 rst_n = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_rst_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_sra();
    logic [15:0] rd; logic [3:0] rt; int lat;
    do_op(16'h8001, 4'd1, 2'b11, 4'h3, rd, rt, lat);
    total++; if (rd !== 16'hC000) begin bad++; $display("FAIL sra1_data: got %h want c000", rd); end
    total++; if (rt !== 4'h3) begin bad++; $display("FAIL sra1_tag: got %h want 3", rt); end
    total++; if (lat != 4) begin bad++; $display("FAIL sra1_latency: got %0d want 4", lat); end
    do_op(16'h7FF0, 4'd15, 2'b11, 4'h4, rd, rt, lat);
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL sra15_pos: got %h want 0000", rd); end
    do_op(16'h8000, 4'd15, 2'b11, 4'h5, rd, rt, lat);
    total++; if (rd !== 16'hFFFF) begin bad++; $display("FAIL sra15_neg: got %h want ffff", rd); end
  endtask

  task automatic test_rotates();
    logic [15:0] rd; logic [3:0] rt; int lat;
    do_op(16'h8001, 4'd4, 2'b00, 4'h1, rd, rt, lat);
    total++; if (rd !== 16'h0018) begin bad++; $display("FAIL rol4: got %h want 0018", rd); end
    do_op(16'h0001, 4'd1, 2'b10, 4'h2, rd, rt, lat);
    total++; if (rd !== 16'h8000) begin bad++; $display("FAIL ror1: got %h want 8000", rd); end
    do_op(16'h00FF, 4'd8, 2'b01, 4'h3, rd, rt, lat);
    total++; if (rd !== 16'hFF00) begin bad++; $display("FAIL sll8: got %h want ff00", rd); end
    do_op(16'h0001, 4'd15, 2'b01, 4'h4, rd, rt, lat);
    total++; if (rd !== 16'h8000) begin bad++; $display("FAIL sll15: got %h want 8000", rd); end
    do_op(16'h0001, 4'd15, 2'b00, 4'h5, rd, rt, lat);
    total++; if (rd !== 16'h8000) begin bad++; $display("FAIL rol15: got %h want 8000", rd); end
    do_op(16'h8000, 4'd15, 2'b10, 4'h6, rd, rt, lat);
    total++; if (rd !== 16'h0001) begin bad++; $display("FAIL ror15: got %h want 0001", rd); end
    for (int o = 0; o < 4; o++) begin
      do_op(16'hA5A5, 4'd0, 2'(o), 4'(o), rd, rt, lat);
      total++; if (rd !== 16'hA5A5) begin bad++; $display("FAIL cnt0_op%0d: got %h want a5a5", o, rd); end
    end
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (out_valid) begin
        if (first < 0) first = c;
        total++; if (c != 4 + n) begin bad++; $display("FAIL b2b_slot%0d: got cycle %0d want %0d", n, c, 4 + n); end
        if (n < 8) begin
          total++; if (out_tag !== 4'(n)) begin bad++; $display("FAIL b2b_tag%0d: got %h want %h", n, out_tag, n); end
          total++; if (out_data !== v_exp[n]) begin bad++; $display("FAIL b2b_data%0d: got %h want %h", n, out_data, v_exp[n]); end
        end
        n++;
      end
      if (c < 8) begin
        in_valid = 1'b1; in_data = v_data[c]; in_cnt = v_cnt[c]; in_op = v_op[c]; in_tag = 4'(c);
      end else begin
        in_valid = 1'b0;
      end
    end
    total++; if (first != 4) begin bad++; $display("FAIL b2b_first: got %0d want 4", first); end
    total++; if (n != 8) begin bad++; $display("FAIL b2b_count: got %0d want 8", n); end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int ret = 0;
    logic acc;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      out_ready = !(c >= 6 && c < 12);
      if (idx < 8) begin
        in_valid = 1'b1; in_data = v_data[idx]; in_cnt = v_cnt[idx]; in_op = v_op[idx]; in_tag = 4'(idx + 8);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!out_ready && out_valid) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_c%0d: got %b want 0", c, in_ready); end
        if (ret < 8) begin
          total++; if (out_data !== v_exp[ret] || out_tag !== 4'(ret + 8)) begin
            bad++; $display("FAIL bp_hold_c%0d: got %h/%h want %h/%h", c, out_data, out_tag, v_exp[ret], ret + 8);
          end
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (ret >= 8) begin
          bad++; $display("FAIL bp_extra: got extra result tag %h want none", out_tag);
        end else if (out_data !== v_exp[ret] || out_tag !== 4'(ret + 8)) begin
          bad++; $display("FAIL bp_ret%0d: got %h/%h want %h/%h", ret, out_data, out_tag, v_exp[ret], ret + 8);
        end
        ret++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (ret != 8) begin bad++; $display("FAIL bp_count: got %0d want 8", ret); end
    total++; if (idx != 8) begin bad++; $display("FAIL bp_accepted: got %0d want 8", idx); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd; logic [3:0] rt; int lat;
    int stale = 0;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'h1234; in_cnt = 4'd4; in_op = 2'b00; in_tag = 4'h1;
    @(negedge clk);
    in_data = 16'h00FF; in_cnt = 4'd8; in_op = 2'b01; in_tag = 4'h2;
    @(negedge clk);
    in_data = 16'h0001; in_cnt = 4'd1; in_op = 2'b10; in_tag = 4'h3;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_data !== 16'h2341) begin
      bad++; $display("FAIL mid_pre: got %b/%h want 1/2341", out_valid, out_data);
    end
    #3 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 16'h0) begin bad++; $display("FAIL mid_rst_data: got %h want 0000", out_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready: got %b want 1", in_ready); end
    #8 rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    total++; if (stale != 0) begin bad++; $display("FAIL mid_stale: got %0d valid cycles want 0", stale); end
    do_op(16'h00F0, 4'd8, 2'b10, 4'h7, rd, rt, lat);
    total++; if (rd !== 16'hF000 || rt !== 4'h7) begin bad++; $display("FAIL mid_new: got %h/%h want f000/7", rd, rt); end
    total++; if (lat != 4) begin bad++; $display("FAIL mid_latency: got %0d want 4", lat); end
  endtask

`ifdef SHIFTER_FLAGS_EN
  task automatic test_flags();
    logic [15:0] rd; logic [3:0] rt; int lat;
    do_op(16'h8000, 4'd1, 2'b01, 4'h1, rd, rt, lat);
    total++; if (rd !== 16'h0000 || out_zero !== 1'b1) begin bad++; $display("FAIL zero_set: got %h/%b want 0000/1", rd, out_zero); end
    do_op(16'h0001, 4'd1, 2'b01, 4'h2, rd, rt, lat);
    total++; if (rd !== 16'h0002 || out_zero !== 1'b0) begin bad++; $display("FAIL zero_clr: got %h/%b want 0002/0", rd, out_zero); end
  endtask
`endif

  initial begin
    test_reset();
    test_sra();
    test_rotates();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef SHIFTER_FLAGS_EN
    test_flags();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
